seq_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a bit pattern, length and repeat count through a valid/ready handshake, then shifts the pattern out one bit per clock, MSB-first, on a single-bit stream. It is the stimulus source for the team's Mealy/Moore sequence-detector FSMs, driving their X input in place of hand-written bench stimulus. It is also used on-chip as a self-test pattern source.

---
 rtl/seq_pattern_tx.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Brief    : Serial MSB-first pattern transmitter with repeat count and a
//            valid/ready start handshake; SEQ_TX_GAP_EN inserts idle gaps
//            between repetitions.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH) + 1,
  parameter int REPW  = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [REPW-1:0]  reps,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LW-1:0] c_WIDTH = LW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef SEQ_TX_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  pat_q;
  logic [IW-1:0]     len_m1_q;
  logic [IW-1:0]     idx_q;
  logic [REPW-1:0]   rep_q;
  logic              x_out_q;
  logic              x_valid_q;
  logic              busy_q;
  logic              done_q;

`ifdef SEQ_TX_GAP_EN
  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] c_GAP_M1 = GW'(GAP - 1);
  logic [GW-1:0]            gap_q;
`endif

  logic [LW-1:0] w_len_clamp;
  logic [IW-1:0] w_len_m1;

  // Over-long requests are truncated to the physical pattern width.
  assign w_len_clamp = (len > c_WIDTH) ? c_WIDTH : len;
  assign w_len_m1    = IW'(w_len_clamp - LW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_m1_q  <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TX_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_valid) begin
            pat_q    <= pattern;
            len_m1_q <= w_len_m1;
            idx_q    <= w_len_m1;
            rep_q    <= reps;
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_SHIFT;
              busy_q    <= 1'b1;
              x_valid_q <= 1'b1;
              x_out_q   <= pattern[w_len_m1];
            end
          end
        end
        S_SHIFT: begin
          if (idx_q != '0) begin
            idx_q   <= idx_q - IW'(1);
            x_out_q <= pat_q[idx_q - IW'(1)];
          end else if (rep_q != '0) begin
            rep_q <= rep_q - REPW'(1);
            idx_q <= len_m1_q;
`ifdef SEQ_TX_GAP_EN
            state_q   <= S_GAP;
            gap_q     <= c_GAP_M1;
            x_valid_q <= 1'b0;
            x_out_q   <= 1'b0;
`else
            x_out_q   <= pat_q[len_m1_q];
`endif
          end else begin
            state_q   <= S_DONE;
            x_valid_q <= 1'b0;
            x_out_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
`ifdef SEQ_TX_GAP_EN
        S_GAP: begin
          if (gap_q == '0) begin
            state_q   <= S_SHIFT;
            x_valid_q <= 1'b1;
            x_out_q   <= pat_q[idx_q];
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Brief    : Directed self-checking bench for seq_pattern_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

`ifdef SEQ_TX_GAP_EN
  localparam int GAPC = 2;
`else
  localparam int GAPC = 0;
`endif
  localparam int MAXC = 80;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       x_out, x_valid, busy, done;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(.WIDTH(8), .LW(4), .REPW(4), .GAP(2)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .len(len), .reps(reps),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accepts a request, then samples every cycle at the falling edge until done.
  // Returns the valid bits, their count, idle-before-done cycles, done cycle
  // index relative to the accept edge, and count of "011" sub-sequences.
  task automatic run_frame(input string tag, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input bit hold,
                           output logic [31:0] bits, output int nb, output int ng,
                           output int dc, output int det);
    int         berr;
    logic [2:0] sh;
    pattern = p; len = l; reps = r; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start_valid = 1'b0;
    pattern = ~p; len = 4'd5; reps = 4'd7;
    bits = '0; nb = 0; ng = 0; dc = 0; det = 0; berr = 0; sh = 3'b111;
    for (int c = 1; c <= MAXC && dc == 0; c++) begin
      if (done) begin
        dc = c;
        if (busy || x_valid || start_ready) berr++;
      end else begin
        if (x_valid) begin
          bits = {bits[30:0], x_out};
          nb++;
          sh = {sh[1:0], x_out};
          if (sh == 3'b011) det++;
        end else begin
          ng++;
          if (x_out) berr++;
        end
        if (!busy || start_ready) berr++;
        @(negedge clk);
      end
    end
    check({tag, " integrity"}, berr, 0);
  endtask

  logic [31:0] bits;
  int          nb, ng, dc, det;
  bit          seen;

  initial begin
    // Asynchronous reset with the clock stopped.
    #3 reset = 1'b1;
    #1;
    check("rst x_out", x_out, 0);
    check("rst x_valid", x_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst start_ready", start_ready, 1);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_frame("single", 8'h0B, 4'd4, 4'd0, 1'b0, bits, nb, ng, dc, det);
    check("single bits", bits, 32'hB);
    check("single nbits", nb, 4);
    check("single done cyc", dc, 5);
    @(negedge clk);
    check("single ready k+6", start_ready, 1);

    run_frame("repeat", 8'h06, 4'd3, 4'd2, 1'b0, bits, nb, ng, dc, det);
    check("repeat bits", bits, 32'h1B6);
    check("repeat nbits", nb, 9);
    check("repeat gaps", ng, 2 * GAPC);
    check("repeat done cyc", dc, 10 + 2 * GAPC);
    @(negedge clk);

    run_frame("len0", 8'hFF, 4'd0, 4'd3, 1'b0, bits, nb, ng, dc, det);
    check("len0 nbits", nb, 0);
    check("len0 done cyc", dc, 1);
    @(negedge clk);

    run_frame("len12", 8'hA5, 4'd12, 4'd0, 1'b0, bits, nb, ng, dc, det);
    check("len12 bits", bits, 32'hA5);
    check("len12 nbits", nb, 8);
    check("len12 done cyc", dc, 9);
    @(negedge clk);

    run_frame("len1r15", 8'h01, 4'd1, 4'd15, 1'b0, bits, nb, ng, dc, det);
    check("len1r15 bits", bits, 32'hFFFF);
    check("len1r15 nbits", nb, 16);
    check("len1r15 done cyc", dc, 17 + 15 * GAPC);
    @(negedge clk);

    run_frame("loopback", 8'h73, 4'd8, 4'd0, 1'b0, bits, nb, ng, dc, det);
    check("loopback bits", bits, 32'h73);
    check("loopback detect", det, 2);
    @(negedge clk);

    // start_valid held high: the second frame may only start after done.
    run_frame("hold", 8'h0B, 4'd4, 4'd0, 1'b1, bits, nb, ng, dc, det);
    check("hold bits", bits, 32'hB);
    check("hold done cyc", dc, 5);
    @(negedge clk);
    check("hold ready after done", start_ready, 1);
    check("hold no early frame", x_valid, 0);
    @(negedge clk);
    check("hold next frame valid", x_valid, 1);
    check("hold next frame bit", x_out, 1);
    start_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < MAXC && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    check("hold next frame done", seen, 1);
    @(negedge clk);

    // Abort during bit 2 of a full-width frame.
    pattern = 8'hFF; len = 4'd8; reps = 4'd0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort pre valid", x_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("abort x_valid", x_valid, 0);
    check("abort busy", busy, 0);
    check("abort ready", start_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || x_valid) seen = 1'b1;
    end
    check("abort no done", seen, 0);
    check("abort ready after", start_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
